div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller that sits in the EX stage between the pipeline and the multi-cycle divider. It captures a DIV/DIVU request and its operands, issues the request to the divider with a start/ready handshake, and stalls the pipeline while the division runs. It cancels the division on flush, recovers from a hung divider via a watchdog, and holds the HI/LO write data until the EX stage advances.

## Interface
- `W`, default `` `N_REG `` (32): operand width.
- `TIMEOUT`, default 48: maximum number of BUSY cycles without `i_div_done` before the watchdog fires.

Ports (name, direction, width, meaning):
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_div_req` in 1: a DIV/DIVU instruction is valid in EX.
- `i_div_signed` in 1: 1 = DIV, 0 = DIVU.
- `i_op_a` in W: dividend.
- `i_op_b` in W: divisor.
- `i_flush` in 1: pipeline flush or exception; kills the EX instruction.
- `i_ex_hold` in 1: EX is held by another stage; the instruction does not advance.
- `o_stall_req` out 1: stall request to the pipeline controller.
- `o_hilo_we` out 1: HI/LO write enable.
- `o_hi` out W: remainder.
- `o_lo` out W: quotient.
- `o_div_zero` out 1: divisor was 0.
- `o_err` out 1: watchdog fired; result forced to 0.
- `o_div_start` out 1: divider start.
- `o_div_signed` out 1: divider signed mode.
- `o_div_op0` out W: divider dividend.
- `o_div_op1` out W: divider divisor.
- `o_div_cancel` out 1: divider abort.
- `i_div_ready` in 1: divider idle and able to accept a start.
- `i_div_done` in 1: divider result valid (1-cycle pulse).
- `i_div_result` in 2W: result as {remainder, quotient}; valid only while `i_div_done` = 1.

## Operation
- **States:** IDLE, ISSUE, BUSY, DONE. On reset the state is IDLE and every registered output is 0.
- **IDLE:**
  - If `i_div_req` = 1 and `i_flush` = 0: latch `i_op_a`, `i_op_b` and `i_div_signed`; set `o_div_zero` = (`i_op_b` == 0); go to ISSUE.
- **ISSUE:**
  - `o_div_start` = !`i_flush`, with the latched operands driven on `o_div_op0`/`o_div_op1`/`o_div_signed`.
  - Start is accepted when `o_div_start` & `i_div_ready`. On acceptance, clear the watchdog counter and go to BUSY; otherwise stay in ISSUE.
- **BUSY:**
  - The watchdog counter increments each cycle.
  - On `i_div_done`: latch `o_hi` = `i_div_result[2W-1:W]` and `o_lo` = `i_div_result[W-1:0]`; go to DONE.
  - If the counter reaches TIMEOUT-1 without `i_div_done`: assert `o_div_cancel` for 1 cycle; latch `o_hi` = `o_lo` = 0 and `o_err` = 1; go to DONE.
- **DONE:**
  - `o_hilo_we` = 1; `o_hi`, `o_lo`, `o_div_zero` and `o_err` are held stable.
  - If `i_ex_hold` = 0 (the instruction advances): go to IDLE and clear all result outputs. Otherwise stay in DONE.
- **Abort:** in ISSUE or BUSY, if `i_flush` = 1 or `i_div_req` = 0:
  - assert `o_div_cancel` (combinational, same cycle);
  - discard any `i_div_done` arriving that cycle;
  - go to IDLE.
- **Abort in DONE:** `i_flush` in DONE goes to IDLE with no cancel, and the outputs clear next cycle.
- **Stall:** `o_stall_req` = `i_div_req` & !`i_flush` & (state ≠ DONE). It is combinational, so the stall begins in the request cycle.
- The controller does no arithmetic. Sign handling and the divide-by-zero result are owned by the divider; the controller only passes them through and flags them.

## Timing
- Cycle 0: request seen in IDLE; `o_stall_req` = 1.
- Cycle 1: ISSUE; start accepted if `i_div_ready` = 1.
- Cycle k: `i_div_done` pulse.
- Cycle k+1: DONE, `o_stall_req` = 0, `o_hilo_we` = 1. Pipeline stall lasts k+1 cycles.
- `o_div_start` is never asserted in a cycle with `i_flush` = 1; flush wins over start.
- `i_div_done` and `i_flush` in the same cycle: the result is dropped and the state goes to IDLE.
- Watchdog expiry and `i_div_done` in the same cycle: done wins, with no cancel and no error.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The divider is reset by the same `i_rst_n`, so no cancel is needed.
- A new request is accepted in the cycle after leaving DONE (back-to-back DIVs incur 1 bubble cycle in IDLE).

## Structure
- Package `div_ctrl_pkg`: state enum `div_ctrl_state_e` (IDLE/ISSUE/BUSY/DONE) and the `DIV_CTRL_TIMEOUT` default constant.
- `W` is derived from `` `N_REG `` in `defines.svh`.
- Single flat module. The watchdog is a plain counter inside it; no sub-module.

## Test plan
- **Signed divide:** DIV with -7 / 2, divider done after 33 cycles → `o_hilo_we` at cycle 34, `o_lo` = 0xFFFFFFFD, `o_hi` = 0xFFFFFFFF, stall high for cycles 0–33.
- **Divide by zero:** DIVU with 5 / 0 → `o_div_zero` = 1 in DONE; `o_hi`/`o_lo` equal the divider output; `o_err` = 0.
- **Flush mid-run:** `i_flush` in BUSY cycle 10 → `o_div_cancel` = 1 that cycle, IDLE next, no `o_hilo_we`, a later done pulse is ignored.
- **Held in DONE:** `i_ex_hold` = 1 for 3 cycles in DONE → `o_hilo_we` and data stable for 4 cycles, then cleared.
- **Watchdog:** divider never asserts done, TIMEOUT = 48 → cancel pulse at BUSY cycle 47, DONE with `o_err` = 1, `o_hi` = `o_lo` = 0.
- **Delayed start and start/flush clash:** `i_div_ready` low for 5 cycles → stays in ISSUE with `o_div_start` high, BUSY after ready. A flush coinciding with ready → no start, IDLE next cycle.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - divider controller state type and constants
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } div_ctrl_state_e;

    localparam int DIV_CTRL_TIMEOUT = 48;

endpackage

// File: rtl/defines.svh
// rtl/defines.svh - global datapath width defines
`ifndef DEFINES_SVH
`define DEFINES_SVH

`define N_REG 32

`endif

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage sequencing controller for the multi-cycle divider
`include "defines.svh"

module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int W       = `N_REG,
    parameter int TIMEOUT = DIV_CTRL_TIMEOUT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_div_req,
    input  logic           i_div_signed,
    input  logic [W-1:0]   i_op_a,
    input  logic [W-1:0]   i_op_b,
    input  logic           i_flush,
    input  logic           i_ex_hold,
    output logic           o_stall_req,
    output logic           o_hilo_we,
    output logic [W-1:0]   o_hi,
    output logic [W-1:0]   o_lo,
    output logic           o_div_zero,
    output logic           o_err,
    output logic           o_div_start,
    output logic           o_div_signed,
    output logic [W-1:0]   o_div_op0,
    output logic [W-1:0]   o_div_op1,
    output logic           o_div_cancel,
    input  logic           i_div_ready,
    input  logic           i_div_done,
    input  logic [2*W-1:0] i_div_result
);

    localparam int            CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

    div_ctrl_state_e state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            signed_q, signed_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;
    logic [CW-1:0]   wdog_q, wdog_d;

    logic in_flight;
    logic abort;
    logic start;
    logic wdog_fire;

    assign in_flight = (state_q == ISSUE) || (state_q == BUSY);
    assign abort     = in_flight && (i_flush || !i_div_req);
    // A request dropped in ISSUE aborts, so start is withheld rather than raced against cancel.
    assign start     = (state_q == ISSUE) && !i_flush && i_div_req;
    assign wdog_fire = (state_q == BUSY) && !abort && !i_div_done && (wdog_q == WDOG_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            signed_q <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            signed_q <= signed_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        signed_d = signed_q;
        zero_d   = zero_q;
        err_d    = err_q;
        wdog_d   = wdog_q;

        case (state_q)
            IDLE: begin
                if (i_div_req && !i_flush) begin
                    op_a_d   = i_op_a;
                    op_b_d   = i_op_b;
                    signed_d = i_div_signed;
                    zero_d   = (i_op_b == '0);
                    err_d    = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    zero_d  = 1'b0;
                    state_d = IDLE;
                end else if (start && i_div_ready) begin
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (abort) begin
                    zero_d  = 1'b0;
                    state_d = IDLE;
                end else if (i_div_done) begin
                    hi_d    = i_div_result[2*W-1:W];
                    lo_d    = i_div_result[W-1:0];
                    state_d = DONE;
                end else if (wdog_fire) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DONE: begin
                if (i_flush || !i_ex_hold) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    zero_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_stall_req  = i_div_req && !i_flush && (state_q != DONE);
    assign o_hilo_we    = (state_q == DONE);
    assign o_hi         = hi_q;
    assign o_lo         = lo_q;
    assign o_div_zero   = zero_q;
    assign o_err        = err_q;
    assign o_div_start  = start;
    assign o_div_signed = signed_q;
    assign o_div_op0    = op_a_q;
    assign o_div_op1    = op_b_q;
    assign o_div_cancel = abort || wdog_fire;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl
module tb_div_ctrl;

    localparam int W  = 32;
    localparam int TO = 48;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_div_req, i_div_signed, i_flush, i_ex_hold;
    logic [W-1:0]   i_op_a, i_op_b;
    logic           i_div_ready, i_div_done;
    logic [2*W-1:0] i_div_result;
    logic           o_stall_req, o_hilo_we, o_div_zero, o_err;
    logic           o_div_start, o_div_signed, o_div_cancel;
    logic [W-1:0]   o_hi, o_lo, o_div_op0, o_div_op1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.W(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_div_req(i_div_req), .i_div_signed(i_div_signed),
        .i_op_a(i_op_a), .i_op_b(i_op_b),
        .i_flush(i_flush), .i_ex_hold(i_ex_hold),
        .o_stall_req(o_stall_req), .o_hilo_we(o_hilo_we),
        .o_hi(o_hi), .o_lo(o_lo), .o_div_zero(o_div_zero), .o_err(o_err),
        .o_div_start(o_div_start), .o_div_signed(o_div_signed),
        .o_div_op0(o_div_op0), .o_div_op1(o_div_op1),
        .o_div_cancel(o_div_cancel),
        .i_div_ready(i_div_ready), .i_div_done(i_div_done),
        .i_div_result(i_div_result)
    );

    // Reference divider: {remainder, quotient}; divide by zero returns all-ones quotient and the dividend.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int          sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic idle_inputs();
        i_div_req    = 1'b0;
        i_div_signed = 1'b0;
        i_op_a       = '0;
        i_op_b       = '0;
        i_flush      = 1'b0;
        i_ex_hold    = 1'b0;
        i_div_ready  = 1'b0;
        i_div_done   = 1'b0;
        i_div_result = '0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        checks++;
        if ({o_hilo_we, o_div_start, o_div_cancel, o_stall_req} !== 4'b0) begin
            errors++;
            $display("FAIL %s idle_ctl got we/start/cancel/stall=%b exp 0000", tag,
                     {o_hilo_we, o_div_start, o_div_cancel, o_stall_req});
        end
        checks++;
        if ({o_hi, o_lo, o_div_zero, o_err} !== '0) begin
            errors++;
            $display("FAIL %s idle_res got hi=%h lo=%h zero=%b err=%b exp all 0", tag, o_hi, o_lo, o_div_zero, o_err);
        end
        @(posedge clk); #1;
    endtask

    // Full transaction: ready at cycle 1+rd, done pulse at cycle k, held in DONE for 'hold' extra cycles.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int rd, input int k, input int hold, input bit tail, input string tag);
        logic [63:0] res;
        res = div_model(a, b, sgn);
        for (int c = 0; c <= k + 1 + hold; c++) begin
            i_div_req    = 1'b1;
            i_flush      = 1'b0;
            i_div_signed = sgn;
            i_op_a       = a;
            i_op_b       = b;
            i_div_ready  = (c == 1 + rd);
            i_div_done   = (c == k);
            i_div_result = (c == k) ? res : {$urandom, $urandom};
            i_ex_hold    = (c > k) && (c <= k + hold);
            @(negedge clk);
            checks++;
            if (o_stall_req !== (c <= k)) begin
                errors++;
                $display("FAIL %s stall c=%0d got %b exp %b", tag, c, o_stall_req, (c <= k));
            end
            checks++;
            if (o_div_start !== (c >= 1 && c <= 1 + rd)) begin
                errors++;
                $display("FAIL %s start c=%0d got %b exp %b", tag, c, o_div_start, (c >= 1 && c <= 1 + rd));
            end
            checks++;
            if (o_div_cancel !== 1'b0) begin
                errors++;
                $display("FAIL %s cancel c=%0d got %b exp 0", tag, c, o_div_cancel);
            end
            checks++;
            if (o_hilo_we !== (c > k)) begin
                errors++;
                $display("FAIL %s hilo_we c=%0d got %b exp %b", tag, c, o_hilo_we, (c > k));
            end
            if (c >= 1 && c <= 1 + rd) begin
                checks++;
                if ({o_div_signed, o_div_op0, o_div_op1} !== {sgn, a, b}) begin
                    errors++;
                    $display("FAIL %s operands c=%0d got s=%b %h/%h exp s=%b %h/%h", tag, c,
                             o_div_signed, o_div_op0, o_div_op1, sgn, a, b);
                end
            end
            if (c > k) begin
                checks++;
                if ({o_hi, o_lo, o_div_zero, o_err} !== {res, (b == 32'd0), 1'b0}) begin
                    errors++;
                    $display("FAIL %s result c=%0d got hi=%h lo=%h zero=%b err=%b exp hi=%h lo=%h zero=%b err=0",
                             tag, c, o_hi, o_lo, o_div_zero, o_err, res[63:32], res[31:0], (b == 32'd0));
                end
            end
            @(posedge clk); #1;
        end
        if (tail) begin
            idle_inputs();
            check_idle(tag);
        end
    endtask

    // Abort at cycle ab_c (flush or request drop), optionally with a coinciding done pulse.
    task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int rd,
                             input int ab_c, input bit use_flush, input bit done_at_abort, input string tag);
        for (int c = 0; c <= ab_c; c++) begin
            i_div_req    = !(c == ab_c && !use_flush);
            i_flush      = (c == ab_c) && use_flush;
            i_div_signed = sgn;
            i_op_a       = a;
            i_op_b       = b;
            i_ex_hold    = 1'b0;
            i_div_ready  = (c == 1 + rd);
            i_div_done   = (c == ab_c) && done_at_abort;
            i_div_result = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (o_div_start !== (c >= 1 && c <= 1 + rd && c != ab_c)) begin
                errors++;
                $display("FAIL %s start c=%0d got %b exp %b", tag, c, o_div_start, (c >= 1 && c <= 1 + rd && c != ab_c));
            end
            checks++;
            if (o_div_cancel !== (c == ab_c)) begin
                errors++;
                $display("FAIL %s cancel c=%0d got %b exp %b", tag, c, o_div_cancel, (c == ab_c));
            end
            checks++;
            if ({o_stall_req, o_hilo_we} !== {(c != ab_c), 1'b0}) begin
                errors++;
                $display("FAIL %s stall/we c=%0d got %b%b exp %b0", tag, c, o_stall_req, o_hilo_we, (c != ab_c));
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        i_div_done   = 1'b1;
        i_div_result = {$urandom, $urandom};
        check_idle(tag);
        idle_inputs();
        check_idle(tag);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({o_stall_req, o_hilo_we, o_hi, o_lo, o_div_zero, o_err, o_div_start,
             o_div_signed, o_div_op0, o_div_op1, o_div_cancel} !== '0) begin
            errors++;
            $display("FAIL reset outputs got hi=%h lo=%h op0=%h op1=%h we=%b exp all 0", o_hi, o_lo, o_div_op0, o_div_op1, o_hilo_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 6; c++) begin
            i_div_req = 1'b1; i_div_signed = 1'b1; i_op_a = 32'h1234_5678; i_op_b = 32'h0;
            i_div_ready = (c == 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_hilo_we, o_div_zero, o_err, o_div_start, o_div_cancel, o_div_op0, o_div_signed} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got zero=%b op0=%h start=%b cancel=%b exp all 0", o_div_zero, o_div_op0, o_div_start, o_div_cancel);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_div_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_div_start, o_stall_req} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid idle got start/stall=%b%b exp 01", o_div_start, o_stall_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_div_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid issue got start=%b exp 1", o_div_start);
        end
        @(posedge clk); #1;
        i_div_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_div_cancel !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid drop got cancel=%b exp 1", o_div_cancel);
        end
        @(posedge clk); #1;
        idle_inputs();
        check_idle("reset_mid");
    endtask

    task automatic test_watchdog(input logic [31:0] a, input logic [31:0] b, input int rd);
        int f;
        f = 2 + rd + TO - 1;
        for (int c = 0; c <= f + 1; c++) begin
            i_div_req = 1'b1; i_flush = 1'b0; i_div_signed = 1'b0; i_op_a = a; i_op_b = b;
            i_ex_hold = 1'b0; i_div_ready = (c == 1 + rd); i_div_done = 1'b0;
            i_div_result = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (o_div_cancel !== (c == f)) begin
                errors++;
                $display("FAIL watchdog cancel c=%0d got %b exp %b", c, o_div_cancel, (c == f));
            end
            checks++;
            if ({o_stall_req, o_hilo_we} !== {(c <= f), (c == f + 1)}) begin
                errors++;
                $display("FAIL watchdog stall/we c=%0d got %b%b exp %b%b", c, o_stall_req, o_hilo_we, (c <= f), (c == f + 1));
            end
            if (c == f + 1) begin
                checks++;
                if ({o_hi, o_lo, o_div_zero, o_err} !== {64'd0, (b == 32'd0), 1'b1}) begin
                    errors++;
                    $display("FAIL watchdog result got hi=%h lo=%h zero=%b err=%b exp 0 0 %b 1", o_hi, o_lo, o_div_zero, o_err, (b == 32'd0));
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        check_idle("watchdog");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        sgn;
        int          rd;
        for (int n = 0; n < 8; n++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            rd  = $urandom_range(0, 4);
            run_div(a, b, sgn, rd, 2 + rd + $urandom_range(0, TO - 2), $urandom_range(0, 3),
                    ($urandom_range(0, 1) == 1), "random");
        end
        idle_inputs();
        check_idle("random_end");
        for (int n = 0; n < 6; n++) begin
            rd = $urandom_range(0, 3);
            run_abort($urandom, $urandom, 1'($urandom_range(0, 1)), rd, $urandom_range(1, 2 + rd + 20),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), "rand_abort");
        end
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 33, 0, 1'b1, "signed");
        run_div(32'd5, 32'd0, 1'b0, 0, 10, 0, 1'b1, "div_zero");
        run_abort(32'd100, 32'd7, 1'b0, 0, 12, 1'b1, 1'b0, "flush_mid");
        run_div(32'd1000, 32'd33, 1'b0, 1, 8, 3, 1'b1, "held");
        test_watchdog(32'd77, 32'd3, 0);
        test_watchdog(32'd9, 32'd0, 2);
        run_div(32'd81, 32'd9, 1'b0, 0, 2 + TO - 1, 0, 1'b1, "wdog_vs_done");
        run_div(32'd500, 32'd6, 1'b0, 5, 12, 0, 1'b1, "delayed_start");
        run_abort(32'd40, 32'd4, 1'b1, 5, 6, 1'b1, 1'b0, "start_flush");
        run_abort(32'd40, 32'd4, 1'b0, 0, 9, 1'b1, 1'b1, "done_flush");
        run_div(32'd17, 32'd5, 1'b0, 0, 4, 0, 1'b0, "b2b_1");
        run_div(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, 0, 5, 1, 1'b1, "b2b_2");
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
